pwm_capture_12bit: RTL

//  Receive end of our 12-bit PWM DAC link: measures the duty cycle of an incoming PWM stream and

---
 rtl/dac_pkg.sv | 19 +
 rtl/pwm_sync_edge.sv | 30 +++
 rtl/pwm_capture_12bit.sv | 111 +++++++++++
 3 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the 12-bit PWM DAC link, used by both the transmitter and the capture block.
package dac_pkg;

    localparam int DAC_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_ARM
    } cap_state_e;

    // Clamp a high-time count to the largest code that fits in `width` bits.
    function automatic logic [31:0] sat_code(input logic [31:0] count, input int unsigned width);
        logic [31:0] max_code;
        max_code = (32'd1 << width) - 32'd1;
        return (count > max_code) ? max_code : count;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronises the asynchronous PWM line and flags its rising edges in the clk domain.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic in_s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   in_d_q;

    // NOTE: non-blocking assignments make each stage take the previous stage's old value;
    // blocking ones here would collapse the whole chain into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            in_d_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            in_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign in_s = sync_q[SYNC_STAGES-1];
    assign rise = in_s & ~in_d_q;

endmodule

// File: rtl/pwm_capture_12bit.sv
// PWM duty-cycle receiver: measures the high time over one 2**WIDTH-clock frame after each rising edge.
module pwm_capture_12bit
    import dac_pkg::*;
#(
    parameter int WIDTH          = DAC_WIDTH,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] code_out,
    output logic             code_valid,
    output logic             locked,
    output logic             stuck
);

    localparam int                TIMEOUT_CYCLES = TIMEOUT_FRAMES * (2 ** WIDTH);
    localparam int                IDLE_W         = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST      = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WIDTH-1:0]  WIN_LAST       = '1;

    logic in_s;
    logic rise;

    cap_state_e        state_q;
    logic [WIDTH-1:0]  win_cnt_q;
    logic [WIDTH:0]    hi_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [WIDTH-1:0]  code_out_q;
    logic              code_valid_q;
    logic              locked_q;
    logic              stuck_q;
    logic [WIDTH:0]    hi_cnt_d;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm_in(pwm_in),
        .in_s  (in_s),
        .rise  (rise)
    );

    // One extra bit so a line high for the whole window reaches 2**WIDTH before clamping.
    assign hi_cnt_d = hi_cnt_q + {{WIDTH{1'b0}}, in_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            win_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            idle_cnt_q   <= '0;
            code_out_q   <= '0;
            code_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            code_valid_q <= 1'b0;
            if (!ena) begin
                state_q    <= ST_IDLE;
                win_cnt_q  <= '0;
                hi_cnt_q   <= '0;
                idle_cnt_q <= '0;
            end else begin
                case (state_q)
                    // Rises during a window are ignored; the window always runs to completion.
                    ST_MEASURE: begin
                        if (win_cnt_q == WIN_LAST) begin
                            code_out_q   <= WIDTH'(sat_code(32'(hi_cnt_d), WIDTH));
                            code_valid_q <= 1'b1;
                            locked_q     <= 1'b1;
                            stuck_q      <= 1'b0;
                            state_q      <= ST_ARM;
                            win_cnt_q    <= '0;
                            hi_cnt_q     <= '0;
                        end else begin
                            win_cnt_q <= win_cnt_q + 1'b1;
                            hi_cnt_q  <= hi_cnt_d;
                        end
                    end
                    default: begin
                        if (rise) begin
                            state_q    <= ST_MEASURE;
                            win_cnt_q  <= WIDTH'(1);
                            hi_cnt_q   <= (WIDTH + 1)'(1);
                            idle_cnt_q <= '0;
                            stuck_q    <= 1'b0;
                        end else if (idle_cnt_q == IDLE_LAST) begin
                            code_out_q   <= in_s ? '1 : '0;
                            code_valid_q <= 1'b1;
                            stuck_q      <= 1'b1;
                            locked_q     <= 1'b0;
                            idle_cnt_q   <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign code_out   = code_out_q;
    assign code_valid = code_valid_q;
    assign locked     = locked_q;
    assign stuck      = stuck_q;

endmodule
